fd8_rr_arb: RTL and testbench

- Round-robin arbiter and one-entry holding register that shares a single 8-bit capture register between NREQ requesters.
- Selects one pending requester per load and captures its byte into the register (CE-gated, like the FD8CE-style latch).
- Acknowledges the winner in the same cycle and presents the held byte to one downstream consumer with a VLD/RDY handshake.
- Sits between the per-channel byte producers and the single shared downstream byte path.

---
 rtl/fd8_rr_arb.sv | 159 +++++++++++++++
 tb/tb_fd8_rr_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd8_rr_arb.sv
// -----------------------------------------------------------------------------
// fd8_rr_arb
//
// Round-robin arbiter feeding a single shared W-bit holding register. Each
// cycle the arbiter picks one pending requester (scanning from the rotation
// pointer), acknowledges it combinationally and captures its word at the edge.
// The held word is offered downstream with a VLD/RDY handshake. A new word
// may be captured in the same cycle the held word is consumed, so sustained
// throughput is one word per cycle.
//
// Ports:
//   CK     rising-edge clock
//   RST_N  asynchronous active-low reset
//   REQ    per-requester level request (held until ACK)
//   DIN    requester data, requester i at [i*W +: W]
//   ACK    one-hot combinational grant, high in the capturing cycle
//   O      held word (registered)
//   VLD    O holds an unconsumed word
//   RDY    consumer accepts O this cycle
//   BUSY   VLD or any request pending (combinational)
//   TMO    sticky stall-timeout flag
//
// Build option:
//   FD8ARB_TMO_EN  when defined, a word stalled for TO_CYC cycles is dropped
//                  and TMO is set until reset. When undefined, TMO is tied 0
//                  and a stalled word is held indefinitely.
// -----------------------------------------------------------------------------
module fd8_rr_arb #(
    parameter int NREQ   = 4,
    parameter int W      = 8,
    parameter int TO_CYC = 255
) (
    input  logic              CK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] DIN,
    output logic [NREQ-1:0]   ACK,
    output logic [W-1:0]      O,
    output logic              VLD,
    input  logic              RDY,
    output logic              BUSY,
    output logic              TMO
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fd8_rr_arb: NREQ must be in 2..8");
    end
    if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
        $error("fd8_rr_arb: TO_CYC must be in 1..65535");
    end

    logic [W-1:0]  o_q,   o_d;
    logic          vld_q, vld_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] win_next;
    logic          load;

`ifdef FD8ARB_TMO_EN
    logic [15:0]   cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   cnt_inc;
    logic          stall;
`endif

    // Winner search: first requester at or after the pointer, wrapping.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign win_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

    // Gating with RST_N keeps ACK low during reset even though the
    // registers are already cleared and the search itself is purely combinational.
    assign load = RST_N && win_found && (!vld_q || RDY);

    always_comb begin
        ACK = '0;
        if (load) ACK[win_idx] = 1'b1;
    end

    always_comb begin
        o_d   = o_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
`ifdef FD8ARB_TMO_EN
        stall   = vld_q && !RDY;
        cnt_inc = cnt_q + 16'd1;
        cnt_d   = stall ? cnt_inc : 16'd0;
        tmo_d   = tmo_q;
`endif
        if (load) begin
            o_d   = DIN[int'(win_idx)*W +: W];
            vld_d = 1'b1;
            ptr_d = win_next;
        end else if (vld_q && RDY) begin
            // Consumed with nothing to replace it: O keeps its last value.
            vld_d = 1'b0;
        end
`ifdef FD8ARB_TMO_EN
        // A load requires RDY or an empty register, so it never coincides
        // with a stall; the drop below only ever applies to a stalled word.
        if (stall && cnt_inc == 16'(TO_CYC)) begin
            vld_d = 1'b0;
            cnt_d = 16'd0;
            tmo_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            o_q   <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
`ifdef FD8ARB_TMO_EN
            cnt_q <= 16'd0;
            tmo_q <= 1'b0;
`endif
        end else begin
            o_q   <= o_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
`ifdef FD8ARB_TMO_EN
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
`endif
        end
    end

    assign O    = o_q;
    assign VLD  = vld_q;
    assign BUSY = vld_q || (|REQ);
`ifdef FD8ARB_TMO_EN
    assign TMO  = tmo_q;
`else
    assign TMO  = 1'b0;
`endif

endmodule

// File: tb/tb_fd8_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_fd8_rr_arb
//
// Self-checking bench for fd8_rr_arb (NREQ=4, W=8, TO_CYC=4). Directed tasks
// cover reset, single transfer, rotation, wrap, asynchronous reset and the
// optional stall timeout; a randomized task compares against a transaction-
// level model of the arbiter and holding register.
// -----------------------------------------------------------------------------
module tb_fd8_rr_arb;

    localparam int NREQ   = 4;
    localparam int W      = 8;
    localparam int TO_CYC = 4;

    logic              CK;
    logic              RST_N;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*W-1:0] DIN;
    logic [NREQ-1:0]   ACK;
    logic [W-1:0]      O;
    logic              VLD;
    logic              RDY;
    logic              BUSY;
    logic              TMO;

    int n_checks;
    int n_fail;

    fd8_rr_arb #(.NREQ(NREQ), .W(W), .TO_CYC(TO_CYC)) dut (
        .CK   (CK),
        .RST_N(RST_N),
        .REQ  (REQ),
        .DIN  (DIN),
        .ACK  (ACK),
        .O    (O),
        .VLD  (VLD),
        .RDY  (RDY),
        .BUSY (BUSY),
        .TMO  (TMO)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference model state: word, valid flag, rotation start, stall count.
    int       m_ptr;
    bit       m_vld;
    bit [7:0] m_o;
    int       m_cnt;
    bit       m_tmo;

    function automatic int model_winner(input logic [NREQ-1:0] req);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_o = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_edge(input int win, input logic [NREQ*W-1:0] din, input bit rdy);
        bit stalled;
        stalled = m_vld && !rdy;
        if (win >= 0 && (!m_vld || rdy)) begin
            m_o   = din[win*W +: W];
            m_vld = 1;
            m_ptr = (win + 1) % NREQ;
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
`ifdef FD8ARB_TMO_EN
        if (stalled) begin
            m_cnt++;
            if (m_cnt == TO_CYC) begin
                m_vld = 0; m_cnt = 0; m_tmo = 1;
            end
        end else begin
            m_cnt = 0;
        end
`endif
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; REQ = '0; DIN = '0; RDY = 1'b0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RST_N = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ = 4'b1111; DIN = 32'h44332211; RDY = 1'b1;
        @(negedge CK);
        n_checks++;
        if (ACK !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ack_forced: got %b want 0000", ACK);
        end
        @(negedge CK);
        REQ = '0; RDY = 1'b0;
        RST_N = 1'b1;
        tick();
        @(negedge CK);
        n_checks++;
        if (O !== 8'h00 || VLD !== 1'b0 || ACK !== 4'b0000 || BUSY !== 1'b0 || TMO !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: O=%h VLD=%b ACK=%b BUSY=%b TMO=%b want 00 0 0000 0 0",
                     O, VLD, ACK, BUSY, TMO);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        REQ = 4'b0001; DIN[7:0] = 8'hA5; RDY = 1'b0;
        @(negedge CK);
        n_checks++;
        if (ACK !== 4'b0001 || VLD !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL single_ack: ACK=%b VLD=%b BUSY=%b want 0001 0 1", ACK, VLD, BUSY);
        end
        tick();
        REQ = 4'b0010; DIN[15:8] = 8'h5A;
        for (int c = 0; c < 2; c++) begin
            @(negedge CK);
            n_checks++;
            if (ACK !== 4'b0000 || O !== 8'hA5 || VLD !== 1'b1) begin
                n_fail++; $display("FAIL single_hold[%0d]: ACK=%b O=%h VLD=%b want 0000 a5 1", c, ACK, O, VLD);
            end
            tick();
        end
        RDY = 1'b1;
        @(negedge CK);
        n_checks++;
        if (ACK !== 4'b0010) begin
            n_fail++; $display("FAIL single_consume_load: ACK=%b want 0010", ACK);
        end
        tick();
        REQ = '0;
        @(negedge CK);
        n_checks++;
        if (O !== 8'h5A || VLD !== 1'b1 || ACK !== 4'b0000) begin
            n_fail++; $display("FAIL single_second: O=%h VLD=%b ACK=%b want 5a 1 0000", O, VLD, ACK);
        end
        tick();
        @(negedge CK);
        n_checks++;
        if (VLD !== 1'b0 || BUSY !== 1'b0 || O !== 8'h5A) begin
            n_fail++; $display("FAIL single_drain: VLD=%b BUSY=%b O=%h want 0 0 5a", VLD, BUSY, O);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        REQ = 4'b1111; DIN = 32'h13121110; RDY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CK);
            n_checks++;
            if (ACK !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ACK, 4'(1 << (k % 4)));
            end
            tick();
            n_checks++;
            if (O !== 8'(8'h10 + k % 4) || VLD !== 1'b1) begin
                n_fail++; $display("FAIL rr_data[%0d]: O=%h VLD=%b want %h 1", k, O, VLD, 8'(8'h10 + k % 4));
            end
        end
        REQ = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        REQ = 4'b0100; DIN = 32'hD3C2B1A0; RDY = 1'b1;
        tick();
        REQ = 4'b1001;
        @(negedge CK);
        n_checks++;
        if (ACK !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_first: ACK=%b want 1000", ACK);
        end
        tick();
        n_checks++;
        if (O !== 8'hD3) begin
            n_fail++; $display("FAIL wrap_first_data: O=%h want d3", O);
        end
        @(negedge CK);
        n_checks++;
        if (ACK !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_second: ACK=%b want 0001", ACK);
        end
        tick();
        REQ = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ = 4'b0010; DIN = 32'h00003C00; RDY = 1'b0;
        tick();
        REQ = 4'b0100; DIN[23:16] = 8'h44;
        n_checks++;
        if (O !== 8'h3C || VLD !== 1'b1) begin
            n_fail++; $display("FAIL mid_loaded: O=%h VLD=%b want 3c 1", O, VLD);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (O !== 8'h00 || VLD !== 1'b0 || ACK !== 4'b0000) begin
            n_fail++; $display("FAIL mid_async_clear: O=%h VLD=%b ACK=%b want 00 0 0000", O, VLD, ACK);
        end
        @(negedge CK);
        RST_N = 1'b1;
        REQ = 4'b0101; DIN[7:0] = 8'h55;
        #1;
        n_checks++;
        if (ACK !== 4'b0001) begin
            n_fail++; $display("FAIL mid_ptr_cleared: ACK=%b want 0001", ACK);
        end
        tick();
        REQ = 4'b0100; RDY = 1'b1;
        @(negedge CK);
        n_checks++;
        if (O !== 8'h55 || ACK !== 4'b0100) begin
            n_fail++; $display("FAIL mid_after: O=%h ACK=%b want 55 0100", O, ACK);
        end
        tick();
        REQ = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        REQ = 4'b0001; DIN[7:0] = 8'h77; RDY = 1'b0;
        tick();
        REQ = '0;
`ifdef FD8ARB_TMO_EN
        for (int c = 1; c <= TO_CYC; c++) begin
            @(negedge CK);
            n_checks++;
            if (VLD !== 1'b1 || TMO !== 1'b0 || O !== 8'h77) begin
                n_fail++; $display("FAIL tmo_stall[%0d]: VLD=%b TMO=%b O=%h want 1 0 77", c, VLD, TMO, O);
            end
            tick();
        end
        @(negedge CK);
        n_checks++;
        if (VLD !== 1'b0 || TMO !== 1'b1) begin
            n_fail++; $display("FAIL tmo_drop: VLD=%b TMO=%b want 0 1", VLD, TMO);
        end
        REQ = 4'b0010; DIN[15:8] = 8'h12; RDY = 1'b1;
        tick();
        REQ = '0;
        @(negedge CK);
        n_checks++;
        if (VLD !== 1'b1 || O !== 8'h12 || TMO !== 1'b1) begin
            n_fail++; $display("FAIL tmo_sticky: VLD=%b O=%h TMO=%b want 1 12 1", VLD, O, TMO);
        end
`else
        repeat (10) tick();
        @(negedge CK);
        n_checks++;
        if (VLD !== 1'b1 || TMO !== 1'b0 || O !== 8'h77) begin
            n_fail++; $display("FAIL no_tmo_hold: VLD=%b TMO=%b O=%h want 1 0 77", VLD, TMO, O);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend;
        logic [W-1:0]    data [NREQ];
        logic [NREQ-1:0] exp_ack;
        int              win;
        bit              granted;
        do_reset();
        pend = '0;
        for (int i = 0; i < NREQ; i++) data[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    data[i] = W'($urandom);
                end
                DIN[i*W +: W] = data[i];
            end
            REQ = pend;
            RDY = ($urandom_range(0, 3) != 0);
            win = model_winner(pend);
            granted = (win >= 0) && (!m_vld || RDY);
            exp_ack = granted ? 4'(1 << win) : 4'b0000;
            @(negedge CK);
            n_checks++;
            if (ACK !== exp_ack || VLD !== m_vld || BUSY !== (m_vld || (|pend)) || TMO !== m_tmo
                || (m_vld && O !== m_o)) begin
                n_fail++;
                $display("FAIL rand[%0d]: ACK=%b VLD=%b BUSY=%b TMO=%b O=%h want %b %b %b %b %h",
                         cyc, ACK, VLD, BUSY, TMO, O, exp_ack, m_vld, m_vld || (|pend), m_tmo, m_o);
            end
            model_edge(win, DIN, RDY);
            tick();
            if (granted) begin
                // The winner either withdraws or immediately requests again with new data.
                if ($urandom_range(0, 1) == 0) pend[win] = 1'b0;
                else data[win] = W'($urandom);
            end
        end
        REQ = '0; RDY = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST_N = 1'b0; REQ = '0; DIN = '0; RDY = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
